// File: rtl/bcd_code_editor.sv
// bcd_code_editor: owns the 8-digit BCD lock code and edits it from four
// push-buttons with press detection, hold auto-repeat and synchronous clear.
module bcd_code_editor #(
  parameter logic [31:0] REPEAT_DELAY = 32'd25_000_000,
  parameter logic [31:0] REPEAT_RATE  = 32'd5_000_000,
  parameter int          CNT_W        = 26
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] state,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       clear,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic [3:0] digit5,
  output logic [3:0] digit6,
  output logic [3:0] digit7,
  output logic [3:0] digit8,
  output logic [2:0] position_pointer,
  output logic       edit_pulse
);

  localparam logic [CNT_W-1:0] DLY_LAST =
    CNT_W'(REPEAT_DELAY - 32'd1);
  localparam logic [CNT_W-1:0] RATE_LAST =
    CNT_W'(REPEAT_RATE - 32'd1);

  // button vector bit order: {right, left, down, up}
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [7:0][3:0]  digits_q, digits_d;
  logic [2:0]       ptr_q, ptr_d;
  logic             edit_q, edit_d;

  logic [3:0] press;
  logic [3:0] evt;
  logic       rep;
  logic       one_held;
  logic       en;
  logic       do_up, do_dn, do_lt, do_rt;
  logic [3:0] cur;

  always_comb begin
    sync1_d  = {btn_right, btn_left, btn_down, btn_up};
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    press    = sync2_q & ~prev_q;
    one_held = $onehot(sync2_q);
    rep      = 1'b0;
    cnt_d    = cnt_q + 1'b1;
    phase_d  = phase_q;
    // phase 0 waits the initial delay, phase 1 paces repeats
    if ((sync2_q != prev_q) || !one_held) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (!phase_q && (cnt_q == DLY_LAST)) begin
      rep     = 1'b1;
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (phase_q && (cnt_q == RATE_LAST)) begin
      rep     = 1'b1;
      cnt_d   = '0;
    end

    evt = press | (rep ? sync2_q : 4'b0000);
    en  = (state == 3'd0) || (state == 3'd1) ||
          (state == 3'd3);

    do_up = en & evt[0] & ~evt[1];
    do_dn = en & evt[1] & ~evt[0];
    do_lt = en & evt[2] & ~evt[3];
    do_rt = en & evt[3] & ~evt[2];

    cur      = digits_q[ptr_q];
    digits_d = digits_q;
    ptr_d    = ptr_q;

    if (clear) begin
      digits_d = '0;
      ptr_d    = 3'd0;
    end else begin
      if (do_up)
        digits_d[ptr_q] = (cur == 4'd9) ? 4'd0 : cur + 4'd1;
      else if (do_dn)
        digits_d[ptr_q] = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
      if (do_lt)
        ptr_d = ptr_q + 3'd1;
      else if (do_rt)
        ptr_d = ptr_q - 3'd1;
    end

    edit_d = (digits_d != digits_q) || (ptr_d != ptr_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      digits_q <= '0;
      ptr_q    <= 3'd0;
      edit_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      digits_q <= digits_d;
      ptr_q    <= ptr_d;
      edit_q   <= edit_d;
    end
  end

  assign digit1           = digits_q[0];
  assign digit2           = digits_q[1];
  assign digit3           = digits_q[2];
  assign digit4           = digits_q[3];
  assign digit5           = digits_q[4];
  assign digit6           = digits_q[5];
  assign digit7           = digits_q[6];
  assign digit8           = digits_q[7];
  assign position_pointer = ptr_q;
  assign edit_pulse       = edit_q;

endmodule

// File: tb/tb_bcd_code_editor.sv
// tb_bcd_code_editor: directed stimulus with a behavioural reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_bcd_code_editor;

  localparam int D = 4;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] state = 3'd0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] digit1, digit2, digit3, digit4;
  logic [3:0] digit5, digit6, digit7, digit8;
  logic [2:0] position_pointer;
  logic       edit_pulse;

  int tests = 0;
  int fails = 0;
  int edits = 0;

  bcd_code_editor #(
    .REPEAT_DELAY(32'd4),
    .REPEAT_RATE (32'd2),
    .CNT_W       (26)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .state           (state),
    .btn_up          (btn_up),
    .btn_down        (btn_down),
    .btn_left        (btn_left),
    .btn_right       (btn_right),
    .clear           (clear),
    .digit1          (digit1),
    .digit2          (digit2),
    .digit3          (digit3),
    .digit4          (digit4),
    .digit5          (digit5),
    .digit6          (digit6),
    .digit7          (digit7),
    .digit8          (digit8),
    .position_pointer(position_pointer),
    .edit_pulse      (edit_pulse)
  );

  always #5 clk = ~clk;

  // reference model: inputs seen through a 3-deep sample history,
  // repeats derived from how long the synchronized vector has been stable
  logic [3:0] smp [3];
  int         hold_len;
  int         m_dig [8];
  int         m_ptr;
  int         m_edit;

  initial begin
    for (int i = 0; i < 3; i++) smp[i] = 4'b0;
    for (int i = 0; i < 8; i++) m_dig[i] = 0;
    hold_len = 0;
    m_ptr = 0;
    m_edit = 0;
  end

  always @(posedge clk) begin
    logic [3:0] v, pv, ev;
    int old_dig [8];
    int old_ptr;
    bit en, changed;
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) smp[i] = 4'b0;
      for (int i = 0; i < 8; i++) m_dig[i] = 0;
      hold_len = 0;
      m_ptr = 0;
      m_edit = 0;
    end else begin
      v  = smp[1];
      pv = smp[2];
      if (v != pv) hold_len = 0;
      else hold_len = hold_len + 1;
      ev = v & ~pv;
      if ($countones(v) == 1 && hold_len >= D &&
          ((hold_len - D) % R) == 0)
        ev = ev | v;
      en = (state == 3'd0) || (state == 3'd1) ||
           (state == 3'd3);
      for (int i = 0; i < 8; i++) old_dig[i] = m_dig[i];
      old_ptr = m_ptr;
      if (clear) begin
        for (int i = 0; i < 8; i++) m_dig[i] = 0;
        m_ptr = 0;
      end else if (en) begin
        if (ev[0] && !ev[1])
          m_dig[old_ptr] = (m_dig[old_ptr] + 1) % 10;
        if (ev[1] && !ev[0])
          m_dig[old_ptr] = (m_dig[old_ptr] + 9) % 10;
        if (ev[2] && !ev[3]) m_ptr = (m_ptr + 1) % 8;
        if (ev[3] && !ev[2]) m_ptr = (m_ptr + 7) % 8;
      end
      changed = (m_ptr != old_ptr);
      for (int i = 0; i < 8; i++)
        if (m_dig[i] != old_dig[i]) changed = 1'b1;
      m_edit = changed ? 1 : 0;
      smp[2] = smp[1];
      smp[1] = smp[0];
      smp[0] = {btn_right, btn_left, btn_down, btn_up};
    end
  end

  task automatic check(input string name, input int act,
                       input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // advance to the next falling edge and compare DUT against model
  task automatic tick(input int n = 1);
    logic [34:0] act, exp;
    repeat (n) begin
      @(negedge clk);
      act = {digit8, digit7, digit6, digit5, digit4, digit3,
             digit2, digit1, position_pointer, edit_pulse};
      exp = '0;
      for (int i = 0; i < 8; i++)
        exp[4 + 4*i +: 4] = 4'(m_dig[i]);
      exp[3:1] = 3'(m_ptr);
      exp[0]   = 1'(m_edit);
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL model_cmp t=%0t: got %h expected %h",
                 $time, act, exp);
      end
      if (edit_pulse === 1'b1) edits++;
    end
  endtask

  task automatic pulse(input logic [3:0] b, input int gap);
    {btn_right, btn_left, btn_down, btn_up} = b;
    tick(1);
    {btn_right, btn_left, btn_down, btn_up} = 4'b0;
    tick(gap);
  endtask

  int e0;

  initial begin
    tick(2);
    reset_n = 1'b1;
    check("rst_digits", {digit8, digit7, digit6, digit5,
                         digit4, digit3, digit2, digit1}, 0);
    check("rst_ptr", position_pointer, 0);
    check("rst_edit", edit_pulse, 0);
    tick(2);

    btn_up = 1'b1;
    tick(1);
    btn_up = 1'b0;
    tick(1);
    check("up_edge2", digit1, 0);
    tick(1);
    check("up_edge3", digit1, 1);
    check("up_edit", edit_pulse, 1);
    tick(1);
    check("up_edit_off", edit_pulse, 0);
    tick(2);

    for (int i = 0; i < 10; i++) pulse(4'b0001, 4);
    check("up_wrap", digit1, 1);

    pulse(4'b1000, 4);
    check("right_wrap", position_pointer, 7);
    pulse(4'b0010, 4);
    check("down_wrap", digit8, 9);

    state = 3'd1;
    e0 = edits;
    btn_up = 1'b1;
    tick(12);
    btn_up = 1'b0;
    tick(6);
    check("hold_digit8", digit8, 4);
    check("hold_events", edits - e0, 5);

    e0 = edits;
    btn_up = 1'b1;
    btn_down = 1'b1;
    tick(3);
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(6);
    check("updn_edits", edits - e0, 0);
    check("updn_digit8", digit8, 4);

    for (int i = 0; i < 3; i++) pulse(4'b0100, 4);
    check("left_to_2", position_pointer, 2);
    pulse(4'b0101, 4);
    check("diag_digit3", digit3, 1);
    check("diag_ptr", position_pointer, 3);

    state = 3'd2;
    e0 = edits;
    pulse(4'b0001, 4);
    pulse(4'b0100, 4);
    check("gated_digit4", digit4, 0);
    check("gated_ptr", position_pointer, 3);
    check("gated_edits", edits - e0, 0);

    state = 3'd0;
    pulse(4'b0001, 4);
    check("set_digit4", digit4, 1);
    state = 3'd2;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_digits", {digit8, digit7, digit6, digit5,
                         digit4, digit3, digit2, digit1}, 0);
    check("clr_ptr", position_pointer, 0);
    check("clr_edit", edit_pulse, 1);
    tick(2);

    state = 3'd0;
    btn_up = 1'b1;
    tick(9);
    reset_n = 1'b0;
    btn_up = 1'b0;
    tick(2);
    check("mid_rst_digits", {digit8, digit7, digit6, digit5,
                             digit4, digit3, digit2, digit1}, 0);
    check("mid_rst_edit", edit_pulse, 0);
    reset_n = 1'b1;
    tick(8);
    check("post_rst_quiet", {digit8, digit7, digit6, digit5,
                             digit4, digit3, digit2, digit1}, 0);
    pulse(4'b0001, 4);
    check("post_rst_press", digit1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
